// File: rtl/ro_freq_pkg.sv
// Shared types and register-map constants for the ring-oscillator frequency counter.
package ro_freq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCount,
      StLatch
   } state_e;

   // Register offsets as word indices, taken from wbs_adr_i[3:2]
   localparam logic [1:0] CTRL_OFF   = 2'd0;
   localparam logic [1:0] WINDOW_OFF = 2'd1;
   localparam logic [1:0] COUNT_OFF  = 2'd2;
   localparam logic [1:0] STATUS_OFF = 2'd3;

   // CTRL bits
   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_CONT  = 1;
   localparam int unsigned CTRL_ABORT = 2;

   // STATUS bits
   localparam int unsigned STAT_BUSY = 0;
   localparam int unsigned STAT_DONE = 1;
   localparam int unsigned STAT_OVF  = 2;

endpackage

// File: rtl/ro_freq_counter_if.sv
// Wishbone classic slave bundle for the frequency counter.
interface ro_freq_counter_if;

   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for the asynchronous oscillator plus rising-edge pulse.
module ro_sync_edge (
   input  logic wb_clk_i,
   input  logic wb_rst_n_i,
   input  logic ro_in,
   output logic edge_o
);

   // [1:0] is the synchronizer, [2] holds the previous synchronized level
   logic [2:0] sync_q;

   // Shift the oscillator level through the synchronizer chain
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], ro_in};
      end
   end

   assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ro_freq_counter.sv
// Wishbone-readable gated edge counter for the ring-oscillator mux output.
module ro_freq_counter
   import ro_freq_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter logic [31:0] DEFAULT_WINDOW = 32'd1_000_000
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_n_i,
   ro_freq_counter_if.slave        wbs,
   input  logic                    ro_in,
   output logic                    done_o
);

   state_e      state_q, state_d;
   logic        ack_q, hold_q;
   logic [31:0] window_q, win_cnt_q, live_cnt_q, count_q;
   logic        cont_q, done_q, done_d, ovf_q, ovf_d;
   logic        ro_edge;
   logic        load_win, clr_live, latch_now, edge_cnt, sat_hit;
   logic [1:0]  off;
   logic        hit, wr_en, ctrl_wr, status_wr, window_wr, start, abort;
   logic [31:0] rdata;
   logic        unused_adr;

   ro_sync_edge u_sync_edge (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n_i (wb_rst_n_i),
      .ro_in      (ro_in),
      .edge_o     (ro_edge)
   );

   assign unused_adr = ^wbs.wbs_adr_i[1:0];

   assign off       = wbs.wbs_adr_i[3:2];
   assign hit       = wbs.wbs_stb_i & wbs.wbs_cyc_i &
                      (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   // Writes land on the ack cycle while the master still holds address and data
   assign wr_en     = ack_q & wbs.wbs_we_i;
   assign ctrl_wr   = wr_en & (off == CTRL_OFF);
   assign window_wr = wr_en & (off == WINDOW_OFF);
   assign status_wr = wr_en & (off == STATUS_OFF);
   assign start     = ctrl_wr & wbs.wbs_dat_i[CTRL_START];
   assign abort     = ctrl_wr & wbs.wbs_dat_i[CTRL_ABORT];

   // One-cycle ack; hold_q blocks a second ack until stb has dropped
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         ack_q  <= 1'b0;
         hold_q <= 1'b0;
      end else begin
         ack_q  <= hit & ~ack_q & ~hold_q;
         hold_q <= wbs.wbs_stb_i & (ack_q | hold_q);
      end
   end

   // Read mux, forced to zero outside the ack cycle
   always_comb begin
      rdata = '0;
      if (ack_q && !wbs.wbs_we_i) begin
         case (off)
            CTRL_OFF:   rdata = {30'b0, cont_q, 1'b0};
            WINDOW_OFF: rdata = window_q;
            COUNT_OFF:  rdata = count_q;
            STATUS_OFF: rdata = {29'b0, ovf_q, done_q, (state_q != StIdle)};
            default:    rdata = '0;
         endcase
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = rdata;
   assign done_o        = (state_q == StLatch);

   // Next state: ABORT beats START, START restarts from any state
   always_comb begin
      state_d  = state_q;
      load_win = 1'b0;
      clr_live = 1'b0;
      if (abort) begin
         state_d = StIdle;
      end else if (start) begin
         load_win = 1'b1;
         clr_live = 1'b1;
         state_d  = (window_q == '0) ? StLatch : StCount;
      end else begin
         case (state_q)
            StCount: begin
               if (win_cnt_q <= 32'd1) state_d = StLatch;
            end
            StLatch: begin
               if (cont_q) begin
                  load_win = 1'b1;
                  clr_live = 1'b1;
                  state_d  = (window_q == '0) ? StLatch : StCount;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign latch_now = (state_q == StLatch) & ~abort;
   assign edge_cnt  = (state_q == StCount) & ro_edge & ~clr_live;
   assign sat_hit   = edge_cnt & (live_cnt_q == '1);

   // Sticky status flags: W1C, cleared on START, set by window end or saturation
   always_comb begin
      done_d = done_q;
      ovf_d  = ovf_q;
      if (status_wr && wbs.wbs_dat_i[STAT_DONE]) done_d = 1'b0;
      if (status_wr && wbs.wbs_dat_i[STAT_OVF])  ovf_d  = 1'b0;
      if (start && !abort) begin
         done_d = 1'b0;
         ovf_d  = 1'b0;
      end
      if (state_d == StLatch) done_d = 1'b1;
      if (sat_hit)            ovf_d  = 1'b1;
   end

   // FSM state, counters and software-visible registers
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q    <= StIdle;
         window_q   <= DEFAULT_WINDOW;
         win_cnt_q  <= '0;
         live_cnt_q <= '0;
         count_q    <= '0;
         cont_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;

         if (load_win) begin
            win_cnt_q <= window_q;
         end else if (state_q == StCount) begin
            win_cnt_q <= win_cnt_q - 32'd1;
         end

         if (clr_live) begin
            live_cnt_q <= '0;
         end else if (edge_cnt && !sat_hit) begin
            live_cnt_q <= live_cnt_q + 32'd1;
         end

         if (latch_now) count_q <= live_cnt_q;
         if (ctrl_wr)   cont_q  <= wbs.wbs_dat_i[CTRL_CONT];

         if (window_wr) begin
            for (int b = 0; b < 4; b++) begin
               if (wbs.wbs_sel_i[b]) window_q[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8];
            end
         end
      end
   end

endmodule
